load_store_unit: RTL and testbench

- MEM-stage block that consumes the decoded memory controls (MemReadEn, MemWriteEn, MemSize, LoadSize) after they pass through EX.
- Runs one data-memory transaction per instruction over a req/ready bus, building byte strobes, lane-replicated store data and sign-extended load data.
- Stalls the pipeline until the bus completes.
- Flags misaligned accesses and bus timeouts.

---
 rtl/load_store_unit_if.sv | 30 +++
 rtl/load_store_unit.sv | 205 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : load_store_unit_if                                           |
// | Brief    : Data-memory req/ready bus between the LSU and data memory.   |
// | Revision : 1.0  initial release                                         |
// +-------------------------------------------------------------------------+
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_ready;
  logic [31:0]       mem_rdata;

  // LSU side: issues requests, receives completion and read data
  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  // Memory side: observes requests, answers with ready/rdata
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : load_store_unit                                              |
// | Brief    : MEM-stage load/store unit. One bus transaction per           |
// |            instruction, byte strobes, lane-replicated store data,       |
// |            sign-extended loads, misalign and bus-timeout flags.         |
// | Revision : 1.0  initial release                                         |
// +-------------------------------------------------------------------------+
module load_store_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              valid_in,
  input  wire logic              mem_read_en,
  input  wire logic              mem_write_en,
  input  wire logic [1:0]        mem_size,
  input  wire logic [1:0]        load_size,
  input  wire logic [ADDR_W-1:0] addr,
  input  wire logic [31:0]       store_data,
  input  wire logic [4:0]        rd_in,
  input  wire logic              flush,
  load_store_unit_if.master      bus,
  output logic                   stall,
  output logic                   load_valid,
  output logic [31:0]            load_data,
  output logic [4:0]             load_rd,
  output logic                   misalign_err,
  output logic                   bus_err
);

  // Counter only has to reach TIMEOUT-1, then it saturates
  localparam int                  c_cnt_w   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(TIMEOUT - 1);
  localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_cnt_w-1:0]  r_cnt;
  logic                r_req;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [3:0]          r_wstrb;
  logic [4:0]          r_rd;
  logic [1:0]          r_lsize;
  logic [1:0]          r_boff;
  logic                r_is_load;
  logic                r_kill;

  logic                w_access;
  logic                w_misal;
  logic                w_issue;
  logic                w_done;
  logic                w_timeout;
  logic                w_load_ok;
  logic [3:0]          w_wstrb;
  logic [31:0]         w_wdata;
  logic [7:0]          w_lbyte;
  logic [15:0]         w_lhalf;
  logic [31:0]         w_ldata;

  assign bus.mem_req   = r_req;
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_wstrb = r_wstrb;

  // Request qualification; a flushed slot never reaches the bus
  always_comb begin
    w_access = valid_in & (mem_read_en | mem_write_en);
    case (mem_size)
      2'b00:   w_misal = 1'b0;
      2'b01:   w_misal = addr[0];
      default: w_misal = |addr[1:0];
    endcase
    w_issue   = (r_state == S_IDLE) & w_access & ~w_misal & ~flush;
    w_done    = (r_state == S_BUSY) & bus.mem_ready;
    w_timeout = (r_state == S_BUSY) & ~bus.mem_ready & (r_cnt == c_cnt_last);
    w_load_ok = w_done & r_is_load & ~r_kill & ~flush;
  end

  // Store strobes and lane-replicated data; loads write no lanes
  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = 32'h0;
    if (mem_write_en) begin
      case (mem_size)
        2'b00: begin
          w_wstrb = 4'b0001 << addr[1:0];
          w_wdata = {4{store_data[7:0]}};
        end
        2'b01: begin
          w_wstrb = addr[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{store_data[15:0]}};
        end
        default: begin
          w_wstrb = 4'b1111;
          w_wdata = store_data;
        end
      endcase
    end
  end

  // Lane extraction and sign extension of the returned word
  always_comb begin
    w_lbyte = bus.mem_rdata[{r_boff, 3'b000} +: 8];
    w_lhalf = r_boff[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (r_lsize)
      2'b00:   w_ldata = {{24{w_lbyte[7]}}, w_lbyte};
      2'b01:   w_ldata = {{16{w_lhalf[15]}}, w_lhalf};
      default: w_ldata = bus.mem_rdata;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and pipeline stall
  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    case (r_state)
      S_IDLE: begin
        stall = w_access & ~w_misal & ~flush;
        if (w_issue) w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        stall = 1'b1;
        if (w_done | w_timeout) w_state_nxt = S_RESP;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus request, timeout counter, response pulses and held load result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= 32'h0;
      r_wstrb      <= 4'b0000;
      r_rd         <= 5'd0;
      r_lsize      <= 2'b00;
      r_boff       <= 2'b00;
      r_is_load    <= 1'b0;
      r_kill       <= 1'b0;
      load_valid   <= 1'b0;
      load_data    <= 32'h0;
      load_rd      <= 5'd0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      misalign_err <= (r_state == S_IDLE) & w_access & w_misal & ~flush;
      bus_err      <= w_timeout;
      load_valid   <= w_load_ok;
      if (w_load_ok) begin
        load_data <= w_ldata;
        load_rd   <= r_rd;
      end
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_cnt     <= '0;
            r_req     <= 1'b1;
            r_we      <= mem_write_en;
            r_addr    <= {addr[ADDR_W-1:2], 2'b00};
            r_wdata   <= w_wdata;
            r_wstrb   <= w_wstrb;
            r_rd      <= rd_in;
            r_lsize   <= load_size;
            r_boff    <= addr[1:0];
            r_is_load <= ~mem_write_en;
            r_kill    <= 1'b0;
          end
        end
        S_BUSY: begin
          if (flush) r_kill <= 1'b1;
          if (w_done | w_timeout) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_wstrb <= 4'b0000;
          end else if (r_cnt != c_cnt_last) begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : tb_load_store_unit                                           |
// | Brief    : Directed and randomized transactions for load_store_unit,    |
// |            checked against an arithmetic model of the access rules.     |
// | Revision : 1.0  initial release                                         |
// +-------------------------------------------------------------------------+
module tb_load_store_unit;

  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [1:0]  mem_size;
  logic [1:0]  load_size;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [4:0]  rd_in;
  logic        flush;
  logic        stall;
  logic        load_valid;
  logic [31:0] load_data;
  logic [4:0]  load_rd;
  logic        misalign_err;
  logic        bus_err;

  int          n_checks;
  int          n_fail;
  logic [31:0] exp_ld_data;
  logic [4:0]  exp_ld_rd;

  load_store_unit_if #(.ADDR_W(ADDR_W)) bus_if ();

  load_store_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .mem_size     (mem_size),
    .load_size    (load_size),
    .addr         (addr),
    .store_data   (store_data),
    .rd_in        (rd_in),
    .flush        (flush),
    .bus          (bus_if.master),
    .stall        (stall),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_rd      (load_rd),
    .misalign_err (misalign_err),
    .bus_err      (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: bytes touched, strobes, replicated data and extended load
  function automatic int access_bytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] lsz, input logic [31:0] a,
                                             input logic [31:0] rdata);
    int          nb;
    int          off;
    logic [31:0] v;
    logic [31:0] mask;
    nb  = access_bytes(lsz);
    off = int'(a % 4) & ~(nb - 1);
    v   = rdata >> (8 * off);
    if (nb < 4) begin
      mask = (32'd1 << (8 * nb)) - 32'd1;
      v    = v & mask;
      if (v[8*nb-1]) v = v | ~mask;
    end
    return v;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_req"},  bus_if.mem_req, 1'b0);
    check_eq({tag, "_lv"},   load_valid, 1'b0);
    check_eq({tag, "_mis"},  misalign_err, 1'b0);
    check_eq({tag, "_berr"}, bus_err, 1'b0);
  endtask

  // One instruction through the MEM stage; memory answers after wait_n
  // BUSY cycles, flush is raised for one cycle at BUSY cycle flush_at
  task automatic run_txn(input logic vin, input logic rd_en, input logic wr_en,
                         input logic [1:0] sz, input logic [1:0] lsz,
                         input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                         input int wait_n, input logic [31:0] rdata, input int flush_at);
    logic        acc;
    logic        mis;
    logic        store;
    logic        flushed;
    logic        timed_out;
    logic        exp_lv;
    logic        done;
    int          nb;
    logic [3:0]  estrb;
    logic [31:0] ewdata;
    store     = wr_en;
    acc       = vin & (rd_en | wr_en);
    nb        = access_bytes(sz);
    mis       = acc && ((a % nb) != 0);
    estrb     = store ? 4'(((1 << nb) - 1) << (a % 4)) : 4'b0000;
    ewdata    = (nb == 1) ? sd[7:0] * 32'h01010101 :
                (nb == 2) ? sd[15:0] * 32'h00010001 : sd;
    flushed   = 1'b0;
    timed_out = 1'b0;
    done      = 1'b0;

    @(negedge clk);
    valid_in     = vin;
    mem_read_en  = rd_en;
    mem_write_en = wr_en;
    mem_size     = sz;
    load_size    = lsz;
    addr         = a;
    store_data   = sd;
    rd_in        = rd;
    flush        = 1'b0;
    bus_if.mem_ready = 1'b0;
    #1;
    check_eq("stall_idle", stall, acc & ~mis);

    if (!acc || mis) begin
      @(negedge clk);
      check_eq("misalign_pulse", misalign_err, mis);
      check_eq("no_req", bus_if.mem_req, 1'b0);
      valid_in = 1'b0;
      @(negedge clk);
      check_idle_outputs("after_noreq");
      return;
    end

    for (int k = 0; k < TIMEOUT && !done; k++) begin
      @(negedge clk);
      check_eq("busy_req", bus_if.mem_req, 1'b1);
      check_eq("busy_stall", stall, 1'b1);
      check_eq("busy_addr", bus_if.mem_addr, a & ~32'h3);
      check_eq("busy_we", bus_if.mem_we, store);
      check_eq("busy_wstrb", bus_if.mem_wstrb, estrb);
      if (store) check_eq("busy_wdata", bus_if.mem_wdata, ewdata);
      flush = (k == flush_at);
      if (k == flush_at) flushed = 1'b1;
      if (k == wait_n) begin
        bus_if.mem_ready = 1'b1;
        bus_if.mem_rdata = rdata;
        done = 1'b1;
      end else begin
        bus_if.mem_rdata = $urandom;
        if (k == TIMEOUT - 1) timed_out = 1'b1;
      end
    end

    @(negedge clk);
    bus_if.mem_ready = 1'b0;
    flush        = 1'b0;
    valid_in     = 1'b0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    exp_lv = ~store & ~flushed & ~timed_out;
    if (exp_lv) begin
      exp_ld_data = model_load(lsz, a, rdata);
      exp_ld_rd   = rd;
    end
    check_eq("resp_req", bus_if.mem_req, 1'b0);
    check_eq("resp_stall", stall, 1'b0);
    check_eq("resp_load_valid", load_valid, exp_lv);
    check_eq("resp_bus_err", bus_err, timed_out);
    check_eq("resp_load_data", load_data, exp_ld_data);
    check_eq("resp_load_rd", load_rd, exp_ld_rd);

    @(negedge clk);
    check_idle_outputs("after_resp");
    check_eq("hold_load_data", load_data, exp_ld_data);
  endtask

  initial begin
    logic [31:0] ra;
    int          w;
    int          r;
    int          fa;
    n_checks     = 0;
    n_fail       = 0;
    exp_ld_data  = 32'h0;
    exp_ld_rd    = 5'd0;
    rst          = 1'b1;
    valid_in     = 1'b0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    mem_size     = 2'b00;
    load_size    = 2'b00;
    addr         = 32'h0;
    store_data   = 32'h0;
    rd_in        = 5'd0;
    flush        = 1'b0;
    bus_if.mem_ready = 1'b0;
    bus_if.mem_rdata = 32'h0;

    repeat (2) @(negedge clk);
    check_eq("rst_req", bus_if.mem_req, 1'b0);
    check_eq("rst_we", bus_if.mem_we, 1'b0);
    check_eq("rst_addr", bus_if.mem_addr, 32'h0);
    check_eq("rst_wstrb", bus_if.mem_wstrb, 4'h0);
    check_eq("rst_load_data", load_data, 32'h0);
    check_eq("rst_stall", stall, 1'b0);
    rst = 1'b0;

    // Directed cases
    run_txn(1, 1, 0, 2'd2, 2'd2, 32'h100, 32'h0, 5'd7,  0, 32'hDEADBEEF, -1);
    check_eq("lw_const", load_data, 32'hDEADBEEF);
    run_txn(1, 1, 0, 2'd0, 2'd0, 32'h103, 32'h0, 5'd3,  0, 32'h80112233, -1);
    check_eq("lb_const", load_data, 32'hFFFFFF80);
    run_txn(1, 1, 0, 2'd1, 2'd1, 32'h102, 32'h0, 5'd9,  1, 32'h7FFF0000, -1);
    check_eq("lh_const", load_data, 32'h00007FFF);
    run_txn(1, 0, 1, 2'd0, 2'd0, 32'h201, 32'hAB, 5'd1, 0, 32'h0, -1);
    run_txn(1, 0, 1, 2'd2, 2'd2, 32'h302, 32'h1234, 5'd1, 0, 32'h0, -1);
    run_txn(1, 1, 0, 2'd2, 2'd2, 32'h400, 32'h0, 5'd4, TIMEOUT + 4, 32'h0, -1);
    run_txn(1, 1, 0, 2'd2, 2'd2, 32'h404, 32'h0, 5'd5, 3, 32'h55AA55AA, 1);
    run_txn(1, 1, 0, 2'd2, 2'd2, 32'h408, 32'h0, 5'd6, TIMEOUT - 1, 32'hCAFEF00D, -1);
    run_txn(1, 1, 1, 2'd1, 2'd1, 32'h50E, 32'hBEEF, 5'd8, 0, 32'h0, -1);
    run_txn(1, 1, 0, 2'd3, 2'd3, 32'h600, 32'h0, 5'd10, 2, 32'h89ABCDEF, -1);

    // Asynchronous reset while a load is outstanding
    @(negedge clk);
    valid_in = 1'b1; mem_read_en = 1'b1; mem_write_en = 1'b0;
    mem_size = 2'd2; load_size = 2'd2; addr = 32'h700; rd_in = 5'd12;
    @(negedge clk);
    check_eq("pre_rst_req", bus_if.mem_req, 1'b1);
    valid_in = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_req", bus_if.mem_req, 1'b0);
    check_eq("async_rst_addr", bus_if.mem_addr, 32'h0);
    check_eq("async_rst_stall", stall, 1'b0);
    check_eq("async_rst_load_data", load_data, 32'h0);
    check_eq("async_rst_load_rd", load_rd, 5'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_ld_data = 32'h0;
    exp_ld_rd   = 5'd0;
    run_txn(1, 1, 0, 2'd0, 2'd0, 32'h701, 32'h0, 5'd13, 0, 32'h00007F00, -1);

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
      r = $urandom_range(0, 9);
      if (r < 6)       w = r % 3;
      else if (r == 6) w = TIMEOUT - 1;
      else if (r == 7) w = TIMEOUT - 2;
      else             w = TIMEOUT + 3;
      fa = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 2) : -1;
      run_txn(($urandom_range(0, 9) != 0), 1'($urandom), 1'($urandom),
              2'($urandom), 2'($urandom), ra, $urandom, 5'($urandom),
              w, $urandom, fa);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
